// File: rtl/univ_shift_reg_if.sv
// Bus interface for univ_shift_reg: operation select, parallel/serial inputs
// and register contents. When UNIV_SHIFT_REG_SEROUT_EN is defined the bus
// also carries the two registered serial outputs ser_out_l / ser_out_h.
interface univ_shift_reg_if #(
  parameter int DW = 4
);
  logic [1:0]    ctrl;
  logic [DW-1:0] data;
  logic          data_l;
  logic          data_h;
  logic [DW-1:0] q;
`ifdef UNIV_SHIFT_REG_SEROUT_EN
  logic          ser_out_l;
  logic          ser_out_h;

  modport master (
    output ctrl, data, data_l, data_h,
    input  q, ser_out_l, ser_out_h
  );

  modport slave (
    input  ctrl, data, data_l, data_h,
    output q, ser_out_l, ser_out_h
  );
`else
  modport master (
    output ctrl, data, data_l, data_h,
    input  q
  );

  modport slave (
    input  ctrl, data, data_l, data_h,
    output q
  );
`endif
endinterface

// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load, shift left, shift right or hold
// of a DW-bit register every clock. Reset is asynchronous and active-low and
// clears the register immediately. q is driven straight from the flops, so
// there is no combinational path from any input to the output.
// Optional feature macro: UNIV_SHIFT_REG_SEROUT_EN adds registered serial
// outputs carrying the bit shifted out of each end.
module univ_shift_reg #(
  parameter int DW = 4
) (
  input  logic              clk,
  input  logic              async_rst_n,
  univ_shift_reg_if.slave   bus
);

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_SHL   = 2'b10;
  localparam logic [1:0] OP_SHR   = 2'b01;
  localparam logic [1:0] OP_HOLD  = 2'b11;

  logic [DW-1:0] q_r;
  logic [DW-1:0] q_nxt_s;

  // Select the next register value from the current operation.
  always_comb begin
    q_nxt_s = q_r;
    case (bus.ctrl)
      OP_LOAD: q_nxt_s = bus.data;
      OP_SHL:  q_nxt_s = {q_r[DW-2:0], bus.data_l};
      OP_SHR:  q_nxt_s = {bus.data_h, q_r[DW-1:1]};
      OP_HOLD: q_nxt_s = q_r;
      default: q_nxt_s = q_r;
    endcase
  end

  // State register; reset clears it at once regardless of ctrl.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      q_r <= '0;
    end else begin
      q_r <= q_nxt_s;
    end
  end

  assign bus.q = q_r;

`ifdef UNIV_SHIFT_REG_SEROUT_EN
  logic ser_l_r;
  logic ser_h_r;
  logic ser_l_nxt_s;
  logic ser_h_nxt_s;

  // Capture the bit falling off the MSB on a left shift and the LSB on a right shift.
  always_comb begin
    ser_l_nxt_s = ser_l_r;
    ser_h_nxt_s = ser_h_r;
    case (bus.ctrl)
      OP_SHL:  ser_l_nxt_s = q_r[DW-1];
      OP_SHR:  ser_h_nxt_s = q_r[0];
      default: begin
        ser_l_nxt_s = ser_l_r;
        ser_h_nxt_s = ser_h_r;
      end
    endcase
  end

  // Serial-out flops, cleared together with the main register.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      ser_l_r <= 1'b0;
      ser_h_r <= 1'b0;
    end else begin
      ser_l_r <= ser_l_nxt_s;
      ser_h_r <= ser_h_nxt_s;
    end
  end

  assign bus.ser_out_l = ser_l_r;
  assign bus.ser_out_h = ser_h_r;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (DW=4): reset behaviour, a directed
// vector table, an interleaved sequence against a reference model, and the
// serial outputs when UNIV_SHIFT_REG_SEROUT_EN is defined.
module tb_univ_shift_reg;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic async_rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  univ_shift_reg_if #(.DW(DW)) bus ();

  univ_shift_reg #(.DW(DW)) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .bus         (bus)
  );

  typedef struct {
    logic [1:0]    ctrl;
    logic [DW-1:0] data;
    logic          dl;
    logic          dh;
    logic [DW-1:0] exp_q;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one operation, let it take effect on the next rising edge, return at edge+1.
  task automatic apply(input logic [1:0] c, input logic [DW-1:0] d, input logic l, input logic h);
    bus.ctrl   = c;
    bus.data   = d;
    bus.data_l = l;
    bus.data_h = h;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] model_q;
    logic [DW-1:0] exp_q;
    logic [DW-1:0] rd;
    logic          rl;
    logic          rh;
    logic [1:0]    seq [11];

    vecs[0] = '{2'b00, 4'b1011, 1'b1, 1'b1, 4'b1011};
    vecs[1] = '{2'b10, 4'b0000, 1'b0, 1'b1, 4'b0110};
    vecs[2] = '{2'b10, 4'b1111, 1'b1, 1'b0, 4'b1101};
    vecs[3] = '{2'b11, 4'b0101, 1'b1, 1'b0, 4'b1101};
    vecs[4] = '{2'b11, 4'b0010, 1'b0, 1'b1, 4'b1101};
    vecs[5] = '{2'b00, 4'b1001, 1'b0, 1'b0, 4'b1001};
    vecs[6] = '{2'b01, 4'b1111, 1'b0, 1'b1, 4'b1100};
    vecs[7] = '{2'b01, 4'b0000, 1'b1, 1'b0, 4'b0110};

    seq = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b11};

    // Reset held with clock running and a load pending: q must stay 0.
    async_rst_n = 1'b0;
    bus.ctrl    = 2'b00;
    bus.data    = 4'hF;
    bus.data_l  = 1'b1;
    bus.data_h  = 1'b1;
    #1;
    check("reset_initial", bus.q, 4'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold", bus.q, 4'h0);
    end
`ifdef UNIV_SHIFT_REG_SEROUT_EN
    check("reset_ser_l", {3'b000, bus.ser_out_l}, 4'h0);
    check("reset_ser_h", {3'b000, bus.ser_out_h}, 4'h0);
`endif
    async_rst_n = 1'b1;

    // Asynchronous clear mid-cycle from q=A.
    apply(2'b00, 4'hA, 1'b0, 1'b0);
    check("load_A", bus.q, 4'hA);
    #3;
    async_rst_n = 1'b0;
    #1;
    check("async_clear", bus.q, 4'h0);
    #2;
    async_rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].ctrl, vecs[i].data, vecs[i].dl, vecs[i].dh);
      check($sformatf("vec%0d", i), bus.q, vecs[i].exp_q);
    end

    // Interleaved sequence with random data against a reference model.
    model_q = bus.q;
    for (int i = 0; i < 11; i++) begin
      rd = DW'($urandom_range(0, 15));
      rl = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      case (seq[i])
        2'b00:   exp_q = rd;
        2'b10:   exp_q = {model_q[DW-2:0], rl};
        2'b01:   exp_q = {rh, model_q[DW-1:1]};
        default: exp_q = model_q;
      endcase
      apply(seq[i], rd, rl, rh);
      check($sformatf("seq%0d", i), bus.q, exp_q);
      model_q = exp_q;
    end

`ifdef UNIV_SHIFT_REG_SEROUT_EN
    // Serial outputs: bits shifted out of each end, held otherwise.
    apply(2'b00, 4'b1001, 1'b0, 1'b0);
    check("so_load", bus.q, 4'b1001);
    apply(2'b10, 4'b0000, 1'b0, 1'b1);
    check("so_shl_q", bus.q, 4'b0010);
    check("so_shl_ser_l", {3'b000, bus.ser_out_l}, 4'h1);
    apply(2'b01, 4'b0000, 1'b1, 1'b0);
    check("so_shr_q", bus.q, 4'b0001);
    check("so_shr_ser_h", {3'b000, bus.ser_out_h}, 4'h0);
    check("so_shr_ser_l_held", {3'b000, bus.ser_out_l}, 4'h1);
    apply(2'b01, 4'b0000, 1'b1, 1'b0);
    check("so_shr2_ser_h", {3'b000, bus.ser_out_h}, 4'h1);
    apply(2'b11, 4'b1111, 1'b1, 1'b1);
    check("so_hold_ser_h", {3'b000, bus.ser_out_h}, 4'h1);
    check("so_hold_ser_l", {3'b000, bus.ser_out_l}, 4'h1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
- Parameterised universal shift register with a DW-bit state register `q`.
- Four operations per clock, selected by a 2-bit control: parallel load, shift left, shift right, hold.
- Shifts take a 1-bit serial input for the vacated end.
- Used as a generic load/shift/hold building block in datapaths and serialisers; purely synchronous apart from the asynchronous reset.

Parameters:
- DW, 4, register width in bits; legal range DW >= 2.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- async_rst_n  input  1  asynchronous reset, active-low; clears `q` immediately when low.
- ctrl  input  2  operation select: 00 load, 10 shift left, 01 shift right, 11 hold.
- data  input  DW  parallel load value.
- data_l  input  1  serial input entering bit 0 on a shift left.
- data_h  input  1  serial input entering bit DW-1 on a shift right.
- q  output  DW  register contents, driven directly from the flops.

Behaviour:
- Reset: one clock, asynchronous, active-low.
  - async_rst_n low forces q = 0 immediately, without waiting for a clock edge.
  - q stays 0 while async_rst_n is low; reset has priority over every ctrl value.
  - Deassertion is not synchronised inside the block. The first operation occurs on the first rising clk edge with async_rst_n high.
- On each rising clk edge with async_rst_n high:
  - ctrl=00: q <= data (parallel load).
  - ctrl=10: q <= {q[DW-2:0], data_l}. MSB is discarded, data_l enters the LSB.
  - ctrl=01: q <= {data_h, q[DW-1:1]}. LSB is discarded, data_h enters the MSB.
  - ctrl=11: q <= q (hold).
- Latency: the result is visible on q one clock after ctrl/data/data_l/data_h are sampled. Inputs only need to be stable around the rising edge.
- The serial input not used by the current operation is ignored; data is ignored unless ctrl=00.
- Back-to-back mixed operations are allowed in any order with no idle cycles.
- Reset asserted mid-operation: q clears at once; the in-flight operation is lost with no partial update.
- ctrl with X/Z values: unspecified; the bench must not drive them.
- No combinational path from any input to q.

Optional Feature:
- Macro: UNIV_SHIFT_REG_SEROUT_EN.
- Defined: adds two 1-bit registered outputs, ser_out_l and ser_out_h, both reset to 0 by async_rst_n.
  - On a shift left, ser_out_l <= old q[DW-1].
  - On a shift right, ser_out_h <= old q[0].
  - Both hold their value on every other operation.
- Undefined: these ports and flops do not exist; the port list is exactly as above.

Test Plan:
- Reset: hold async_rst_n=0 with clk running and ctrl=00, data=4'hF -> q=4'h0 throughout; q clears asynchronously when async_rst_n falls mid-cycle from q=4'hA.
- Load then shift left: load 4'b1011, then ctrl=10 with data_l=0, then 1 -> q=4'b0110, then 4'b1101.
- Hold: ctrl=11 for 2 clocks with random data/data_l/data_h from q=4'b1101 -> q stays 4'b1101.
- Load then shift right: load 4'b1001, then ctrl=01 with data_h=1, then 0 -> q=4'b1100, then 4'b0110.
- Interleaved sequence: load, L, L, hold, hold, L, L, hold, R, R, hold with random data/serial bits, compared each cycle against a reference model -> exact match on all cycles.
- With UNIV_SHIFT_REG_SEROUT_EN: from q=4'b1001, shift left -> ser_out_l=1; then shift right -> ser_out_h=0 (q[0] after the left shift).
